// File: rtl/entropy_input_pacer.sv
// rtl/entropy_input_pacer.sv - issue-rate pacer and end-of-frame drain/flush controller for the arithmetic encoder
module entropy_input_pacer #(
    parameter int DATA_W     = 48,
    parameter int PIPE_DEPTH = 3,
    parameter int ISSUE_GAP  = 2
) (
    input  logic              clk,
    input  logic              reset_ctrl,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              pipe_valid,
    output logic [DATA_W-1:0] pipe_data,
    output logic              pipe_out_valid,
    output logic              flush_req,
    input  logic              flush_ack,
    output logic              frame_done,
    output logic              busy
);

    localparam int GAP_W = $clog2(ISSUE_GAP) + 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 1);

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [GAP_W-1:0]      gap;
    logic [PIPE_DEPTH-1:0] vsr;
    logic                  handshake;
    logic                  pipe_empty;

    // in_ready is masked by reset so nothing is taken while the block is being cleared
    assign in_ready       = (state == ST_ACCEPT) && (gap == '0) && !reset_ctrl;
    assign handshake      = in_valid && in_ready;
    assign pipe_empty     = !pipe_valid && (vsr == '0);
    assign pipe_out_valid = vsr[PIPE_DEPTH-1];
    assign busy           = (state != ST_ACCEPT) || pipe_valid || (vsr != '0);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            state <= ST_ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and flush-side outputs
    always_comb begin
        state_next = state;
        flush_req  = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_ACCEPT: begin
                if (handshake && in_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_req = 1'b1;
                if (flush_ack) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_next = ST_ACCEPT;
            end
            default: begin
                state_next = ST_ACCEPT;
            end
        endcase
    end

    // Gap counter: reloaded on every handshake, counts down to zero and rests there
    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            gap <= '0;
        end else if (handshake) begin
            gap <= GAP_LOAD;
        end else if (gap != '0) begin
            gap <= gap - GAP_W'(1);
        end
    end

    // Stage-1 issue register; data holds between issues
    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
        end else begin
            pipe_valid <= handshake;
            if (handshake) begin
                pipe_data <= in_data;
            end
        end
    end

    // In-flight tracker mirroring the stage pipeline; top bit is the stage-3 result valid
    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            vsr <= '0;
        end else begin
            vsr[0] <= pipe_valid;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                vsr[i] <= vsr[i-1];
            end
        end
    end

endmodule
